// File: rtl/eth_reset_pkg.sv
// Shared types and defaults for the 10G datapath reset sequencer.
package eth_reset_pkg;

  typedef enum logic [2:0] {
    S_HOLD        = 3'd0,
    S_WAIT_STABLE = 3'd1,
    S_GT_RESET    = 3'd2,
    S_GT_WAIT     = 3'd3,
    S_PCS_RUN     = 3'd4,
    S_READY       = 3'd5
  } state_t;

  localparam int LOCK_STABLE_CYCLES_DEF = 1024;
  localparam int GT_RESET_CYCLES_DEF    = 8;
  localparam int GT_TIMEOUT_CYCLES_DEF  = 65536;
  localparam int MAC_DELAY_CYCLES_DEF   = 16;
  localparam int SYNC_STAGES_DEF        = 2;

  // One shared counter serves every timed state, so it is sized for the longest interval.
  function automatic int cnt_width(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/eth_sync_bit.sv
// Multi-flop synchronizer for a single asynchronous level; resets to 0.
module eth_sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  // NOTE: non-blocking assignments make every stage sample the previous stage's old value,
  // which is what turns this into a shift chain rather than a single wire.
  always_ff @(posedge clk) begin
    if (!reset_n) ff <= '0;
    else          ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/eth_reset_sequencer.sv
// GT -> PCS -> MAC reset sequencer for the 156.25 MHz 10G datapath.
// Optional RESET_SEQ_RELOCK_COUNT_EN adds a saturating count of exits from S_READY.
module eth_reset_sequencer
  import eth_reset_pkg::*;
#(
  parameter int LOCK_STABLE_CYCLES = LOCK_STABLE_CYCLES_DEF,
  parameter int GT_RESET_CYCLES    = GT_RESET_CYCLES_DEF,
  parameter int GT_TIMEOUT_CYCLES  = GT_TIMEOUT_CYCLES_DEF,
  parameter int MAC_DELAY_CYCLES   = MAC_DELAY_CYCLES_DEF,
  parameter int SYNC_STAGES        = SYNC_STAGES_DEF
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_pll_locked,
  input  logic        i_gt_reset_done,
  input  logic        i_block_lock,
  output logic        o_gt_reset,
  output logic        o_pcs_reset_n,
  output logic        o_mac_reset_n,
  output logic        o_ready,
  output logic [2:0]  o_state
`ifdef RESET_SEQ_RELOCK_COUNT_EN
  ,
  output logic [15:0] o_relock_count
`endif
);

  localparam int CNT_W = cnt_width(LOCK_STABLE_CYCLES, GT_RESET_CYCLES,
                                   GT_TIMEOUT_CYCLES, MAC_DELAY_CYCLES);

  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GTR_LAST  = CNT_W'(GT_RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] GTO_LAST  = CNT_W'(GT_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] MAC_LAST  = CNT_W'(MAC_DELAY_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic pll_s, done_s, lock_s;

  eth_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_pll (
    .clk(i_clk), .reset_n(i_reset_n), .d(i_pll_locked), .q(pll_s)
  );
  eth_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_done (
    .clk(i_clk), .reset_n(i_reset_n), .d(i_gt_reset_done), .q(done_s)
  );
  eth_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_lock (
    .clk(i_clk), .reset_n(i_reset_n), .d(i_block_lock), .q(lock_s)
  );

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  // NOTE: both outputs get a default before any branch, so no path leaves them unassigned
  // and no latch is inferred.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (state != S_HOLD && !pll_s) begin
      state_nxt = S_HOLD;
      cnt_nxt   = '0;
    end else begin
      case (state)
        S_HOLD: begin
          if (pll_s) begin
            state_nxt = S_WAIT_STABLE;
            cnt_nxt   = '0;
          end
        end
        S_WAIT_STABLE: begin
          if (cnt == LOCK_LAST) begin
            state_nxt = S_GT_RESET;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
        S_GT_RESET: begin
          if (cnt == GTR_LAST) begin
            state_nxt = S_GT_WAIT;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
        S_GT_WAIT: begin
          if (done_s) begin
            state_nxt = S_PCS_RUN;
            cnt_nxt   = '0;
          end else if (cnt == GTO_LAST) begin
            state_nxt = S_GT_RESET;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
        S_PCS_RUN: begin
          // Count holds at its last value while waiting for block lock.
          if (!done_s) begin
            state_nxt = S_GT_RESET;
            cnt_nxt   = '0;
          end else if (cnt == MAC_LAST) begin
            if (lock_s) begin
              state_nxt = S_READY;
              cnt_nxt   = '0;
            end
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
        S_READY: begin
          if (!done_s) begin
            state_nxt = S_GT_RESET;
            cnt_nxt   = '0;
          end else if (!lock_s) begin
            state_nxt = S_PCS_RUN;
            cnt_nxt   = '0;
          end
        end
        default: begin
          state_nxt = S_HOLD;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state         <= S_HOLD;
      cnt           <= '0;
      o_gt_reset    <= 1'b1;
      o_pcs_reset_n <= 1'b0;
      o_mac_reset_n <= 1'b0;
      o_ready       <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      o_gt_reset    <= (state_nxt == S_HOLD) || (state_nxt == S_GT_RESET);
      o_pcs_reset_n <= (state_nxt == S_PCS_RUN) || (state_nxt == S_READY);
      o_mac_reset_n <= (state_nxt == S_READY);
      o_ready       <= (state_nxt == S_READY);
    end
  end

  assign o_state = state;

`ifdef RESET_SEQ_RELOCK_COUNT_EN
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      o_relock_count <= '0;
    end else if (state == S_READY && state_nxt != S_READY && o_relock_count != 16'hFFFF) begin
      o_relock_count <= o_relock_count + 16'd1;
    end
  end
`endif

endmodule
